// File: rtl/pll_reset_pkg.sv
// pll_reset_pkg: sequencer state encoding, default timing constants and counter-width helper
package pll_reset_pkg;
  typedef enum logic [2:0] {PLL_RST, WAIT_LOCK, STABLE, MEM_REL, RUN, SOFT} state_t;
  localparam int unsigned DEF_PLL_RST_CYCLES = 16;
  localparam int unsigned DEF_LOCK_TIMEOUT   = 500000;
  localparam int unsigned DEF_STABLE_CYCLES  = 1024;
  localparam int unsigned DEF_MEM_HOLD       = 256;
  localparam int unsigned DEF_SOFT_CYCLES    = 64;
  function automatic int cnt_width(input int unsigned a, b, c, d, e);
    int unsigned m;
    m = a;
    m = b > m ? b : m;
    m = c > m ? c : m;
    m = d > m ? d : m;
    m = e > m ? e : m;
    return m > 1 ? $clog2(m) : 1;
  endfunction
endpackage

// File: rtl/sync2_bit.sv
// sync2_bit: 2-flop synchroniser, async active-high reset to 0; ports clk, rst, d (async in), q (synchronised out)
module sync2_bit (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic s_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) {q, s_q} <= 2'b00;
    else     {q, s_q} <= {s_q, d};
endmodule

// File: rtl/pll_reset_seq.sv
// pll_reset_seq: PLL lock wait then ordered mem/core reset release; ports refclk, rst, pll_locked, soft_reset_req in; pll_rst, mem_rst, core_rst, ready, lock_lost, retry_count[3:0] out
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int unsigned PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
  parameter int unsigned LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
  parameter int unsigned STABLE_CYCLES  = DEF_STABLE_CYCLES,
  parameter int unsigned MEM_HOLD       = DEF_MEM_HOLD,
  parameter int unsigned SOFT_CYCLES    = DEF_SOFT_CYCLES
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset_req,
  output logic       pll_rst,
  output logic       mem_rst,
  output logic       core_rst,
  output logic       ready,
  output logic       lock_lost,
  output logic [3:0] retry_count
);
  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, MEM_HOLD, SOFT_CYCLES);
  localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] LT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] ST_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] MH_LAST = CW'(MEM_HOLD - 1);
  localparam logic [CW-1:0] SC_LAST = CW'(SOFT_CYCLES - 1);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      retry_q, retry_d;
  logic            lost_q, lost_d;
  logic            pll_rst_q, mem_rst_q, core_rst_q, ready_q;
  logic            locked_s;

  sync2_bit u_sync (.clk(refclk), .rst(rst), .d(pll_locked), .q(locked_s));

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    lost_d  = lost_q;
    case (state_q)
      PLL_RST:   state_d = cnt_q == PR_LAST ? WAIT_LOCK : PLL_RST;
      WAIT_LOCK: begin
        state_d = locked_s ? STABLE : cnt_q == LT_LAST ? PLL_RST : WAIT_LOCK;
        retry_d = !locked_s && cnt_q == LT_LAST && retry_q != 4'hf ? retry_q + 4'd1 : retry_q;
      end
      STABLE:    state_d = !locked_s ? PLL_RST : cnt_q == ST_LAST ? MEM_REL : STABLE;
      MEM_REL:   state_d = !locked_s ? PLL_RST : cnt_q == MH_LAST ? RUN : MEM_REL;
      RUN: begin
        // lock loss outranks a coincident soft request, which is simply dropped
        state_d = !locked_s ? PLL_RST : soft_reset_req ? SOFT : RUN;
        lost_d  = lost_q | !locked_s;
      end
      SOFT: begin
        state_d = !locked_s ? PLL_RST : cnt_q == SC_LAST ? RUN : SOFT;
        lost_d  = lost_q | !locked_s;
      end
      default:   state_d = PLL_RST;
    endcase
    cnt_d = state_d != state_q ? '0 : cnt_q + 1'b1;
  end

  // outputs are decoded from the next state so each flop tracks state_q with no combinational path to ports
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state_q    <= PLL_RST;
      cnt_q      <= '0;
      retry_q    <= '0;
      lost_q     <= 1'b0;
      pll_rst_q  <= 1'b1;
      mem_rst_q  <= 1'b1;
      core_rst_q <= 1'b1;
      ready_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retry_q    <= retry_d;
      lost_q     <= lost_d;
      pll_rst_q  <= state_d == PLL_RST;
      mem_rst_q  <= state_d inside {PLL_RST, WAIT_LOCK, STABLE};
      core_rst_q <= state_d != RUN;
      ready_q    <= state_d == RUN;
    end

  assign pll_rst     = pll_rst_q;
  assign mem_rst     = mem_rst_q;
  assign core_rst    = core_rst_q;
  assign ready       = ready_q;
  assign lock_lost   = lost_q;
  assign retry_count = retry_q;
endmodule
